// File: rtl/regbank_ic_pkg.sv
// Shared types and default sizes for the regbank_ic register bank.
// Backup sweep states plus the default width and register count.
package regbank_ic_pkg;

    localparam int REGBANK_N_DEFAULT    = 32;
    localparam int REGBANK_NREG_DEFAULT = 8;

    typedef enum logic [1:0] {
        BK_IDLE = 2'd0,
        BK_SCAN = 2'd1,
        BK_SEND = 2'd2,
        BK_DONE = 2'd3
    } bk_state_e;

endpackage

// File: rtl/regbank_ic_backup_fsm.sv
// Backup sweep engine: walks the register index once, streaming dirty entries
// over a valid/ack handshake. Valid holds addr/data stable until the ack edge.
module regbank_ic_backup_fsm
    import regbank_ic_pkg::*;
#(
    parameter  int N    = REGBANK_N_DEFAULT,
    parameter  int NREG = REGBANK_NREG_DEFAULT,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_ack,
    input  logic          i_idx_dirty,
    input  logic [N-1:0]  i_idx_data,
    input  logic          i_wr_hit,
    output logic [AW-1:0] o_idx,
    output logic          o_clr_dirty,
    output logic          o_valid,
    output logic          o_busy,
    output logic          o_done,
    output logic [AW-1:0] o_addr,
    output logic [N-1:0]  o_data,
    output bk_state_e     o_state
);

    bk_state_e     r_state;
    bk_state_e     w_state_nxt;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_nxt;
    logic [AW-1:0] r_addr;
    logic [N-1:0]  r_data;
    logic          r_redirty;
    logic          w_redirty_nxt;
    logic          w_capture;
    logic          w_last;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= BK_IDLE;
            r_idx     <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_redirty <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_redirty <= w_redirty_nxt;
            if (w_capture) begin
                r_addr <= r_idx;
                r_data <= i_idx_data;
            end
        end
    end

    // r_redirty remembers a fresh write to the entry in flight, so the ack
    // must not clear a dirty bit that now covers newer data.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_redirty_nxt = r_redirty;
        w_capture     = 1'b0;
        o_clr_dirty   = 1'b0;
        w_last        = (r_idx == AW'(NREG - 1));
        case (r_state)
            BK_IDLE: begin
                if (i_start) begin
                    w_state_nxt = BK_SCAN;
                    w_idx_nxt   = '0;
                end
            end
            BK_SCAN: begin
                if (i_abort) begin
                    w_state_nxt = BK_IDLE;
                end else if (i_idx_dirty) begin
                    w_state_nxt   = BK_SEND;
                    w_capture     = 1'b1;
                    w_redirty_nxt = i_wr_hit;
                end else if (w_last) begin
                    w_state_nxt = BK_DONE;
                end else begin
                    w_idx_nxt = r_idx + AW'(1);
                end
            end
            BK_SEND: begin
                if (i_abort) begin
                    w_state_nxt = BK_IDLE;
                end else if (i_ack) begin
                    o_clr_dirty = !(r_redirty || i_wr_hit);
                    if (w_last) begin
                        w_state_nxt = BK_DONE;
                    end else begin
                        w_state_nxt = BK_SCAN;
                        w_idx_nxt   = r_idx + AW'(1);
                    end
                end else if (i_wr_hit) begin
                    w_redirty_nxt = 1'b1;
                end
            end
            BK_DONE: begin
                w_state_nxt = BK_IDLE;
            end
            default: begin
                w_state_nxt = BK_IDLE;
            end
        endcase
    end

    assign o_idx   = r_idx;
    assign o_valid = (r_state == BK_SEND);
    assign o_busy  = (r_state == BK_SCAN) || (r_state == BK_SEND);
    assign o_done  = (r_state == BK_DONE);
    assign o_addr  = r_addr;
    assign o_data  = r_data;
    assign o_state = r_state;

endmodule

// File: rtl/regbank_ic.sv
// Register bank with per-entry dirty tracking, restore port and backup sweep.
// Build macro REGBANK_IC_PWR_SIM_EN makes i_pwr_off act as a reset.
module regbank_ic
    import regbank_ic_pkg::*;
#(
    parameter  int N    = REGBANK_N_DEFAULT,
    parameter  int NREG = REGBANK_NREG_DEFAULT,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_wr_en,
    input  logic [AW-1:0]   i_wr_addr,
    input  logic [N-1:0]    i_wr_data,
    input  logic [AW-1:0]   i_rd_addr,
    output logic [N-1:0]    o_rd_data,
    output logic [NREG-1:0] o_dirty_mask,
    input  logic            i_backup_en,
    output logic            o_backup_valid,
    output logic [AW-1:0]   o_backup_addr,
    output logic [N-1:0]    o_backup_data,
    input  logic            i_backup_ack,
    output logic            o_backup_busy,
    output logic            o_backup_done,
    input  logic            i_restore_en,
    input  logic [AW-1:0]   i_restore_addr,
    input  logic [N-1:0]    i_restore_data,
    input  logic            i_rst_drtyctrl,
    input  logic            i_pwr_off,
    output bk_state_e       o_dbg_state
);

    logic [N-1:0]    r_mem [NREG];
    logic [NREG-1:0] r_dirty;
    logic [NREG-1:0] w_dirty_nxt;
    logic            w_rst;
    logic            w_wr_qual;
    logic            w_wr_hit;
    logic            w_clr_dirty;
    logic [AW-1:0]   w_idx;

`ifdef REGBANK_IC_PWR_SIM_EN
    assign w_rst = i_rst | i_pwr_off;
`else
    assign w_rst = i_rst | (i_pwr_off & 1'b0);
`endif

    // Restore owns the storage port; a same-cycle write never qualifies.
    assign w_wr_qual = i_wr_en && !i_restore_en && (i_wr_data != r_mem[i_wr_addr]);
    assign w_wr_hit  = w_wr_qual && (i_wr_addr == w_idx);

    always_ff @(posedge i_clk) begin
        if (w_rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
            r_dirty <= '0;
        end else begin
            if (i_restore_en) begin
                r_mem[i_restore_addr] <= i_restore_data;
            end else if (w_wr_qual) begin
                r_mem[i_wr_addr] <= i_wr_data;
            end
            r_dirty <= w_dirty_nxt;
        end
    end

    always_comb begin
        w_dirty_nxt = r_dirty;
        if (w_clr_dirty) begin
            w_dirty_nxt[w_idx] = 1'b0;
        end
        if (i_restore_en) begin
            w_dirty_nxt[i_restore_addr] = 1'b0;
        end
        if (w_wr_qual) begin
            w_dirty_nxt[i_wr_addr] = 1'b1;
        end
        if (i_rst_drtyctrl) begin
            w_dirty_nxt = '0;
        end
    end

    regbank_ic_backup_fsm #(
        .N    (N),
        .NREG (NREG)
    ) u_backup_fsm (
        .i_clk       (i_clk),
        .i_rst       (w_rst),
        .i_start     (i_backup_en),
        .i_abort     (i_restore_en | i_rst_drtyctrl),
        .i_ack       (i_backup_ack),
        .i_idx_dirty (r_dirty[w_idx]),
        .i_idx_data  (r_mem[w_idx]),
        .i_wr_hit    (w_wr_hit),
        .o_idx       (w_idx),
        .o_clr_dirty (w_clr_dirty),
        .o_valid     (o_backup_valid),
        .o_busy      (o_backup_busy),
        .o_done      (o_backup_done),
        .o_addr      (o_backup_addr),
        .o_data      (o_backup_data),
        .o_state     (o_dbg_state)
    );

    assign o_rd_data    = r_mem[i_rd_addr];
    assign o_dirty_mask = r_dirty;

endmodule

// File: tb/tb_regbank_ic.sv
// Directed self-checking bench for regbank_ic: writes, dirty tracking, backup
// sweeps, aborts, restore priority and reset / power-off behaviour.
module tb_regbank_ic;
    import regbank_ic_pkg::*;

    localparam int N    = 32;
    localparam int NREG = 8;
    localparam int AW   = 3;
    localparam int W    = AW + N;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [N-1:0]    wr_data;
    logic [AW-1:0]   rd_addr;
    logic [N-1:0]    rd_data;
    logic [NREG-1:0] dirty_mask;
    logic            backup_en;
    logic            backup_valid;
    logic [AW-1:0]   backup_addr;
    logic [N-1:0]    backup_data;
    logic            backup_ack;
    logic            backup_busy;
    logic            backup_done;
    logic            restore_en;
    logic [AW-1:0]   restore_addr;
    logic [N-1:0]    restore_data;
    logic            rst_drtyctrl;
    logic            pwr_off;
    bk_state_e       dbg_state;

    int n_total = 0;
    int n_bad   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];

    regbank_ic #(.N(N), .NREG(NREG)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_wr_en        (wr_en),
        .i_wr_addr      (wr_addr),
        .i_wr_data      (wr_data),
        .i_rd_addr      (rd_addr),
        .o_rd_data      (rd_data),
        .o_dirty_mask   (dirty_mask),
        .i_backup_en    (backup_en),
        .o_backup_valid (backup_valid),
        .o_backup_addr  (backup_addr),
        .o_backup_data  (backup_data),
        .i_backup_ack   (backup_ack),
        .o_backup_busy  (backup_busy),
        .o_backup_done  (backup_done),
        .i_restore_en   (restore_en),
        .i_restore_addr (restore_addr),
        .i_restore_data (restore_data),
        .i_rst_drtyctrl (rst_drtyctrl),
        .i_pwr_off      (pwr_off),
        .o_dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [N-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [AW-1:0] a, input logic [N-1:0] d);
        rd_addr = a;
        #0;
        check(tag, rd_data, d);
    endtask

    task automatic start_sweep();
        backup_en = 1'b1;
        tick();
        backup_en = 1'b0;
    endtask

    task automatic wait_valid(input int max_cyc);
        for (int c = 0; c < max_cyc && !backup_valid; c++) tick();
        check("valid_seen", backup_valid, 1'b1);
    endtask

    task automatic wait_done(input int max_cyc);
        for (int c = 0; c < max_cyc && !backup_done; c++) tick();
        check("done_seen", backup_done, 1'b1);
        tick();
        check("done_one_cycle", backup_done, 1'b0);
    endtask

    task automatic count_done(input string tag, input int cycles);
        int n;
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (backup_done) n++;
        end
        check(tag, n, 0);
    endtask

    // Consumer acks one cycle after it first sees valid; beats go to obs_q.
    task automatic run_sweep(input bit keep_en);
        int hold;
        int n_done;
        bit fin;
        logic [W-1:0] got;
        hold = 0; n_done = 0; fin = 0;
        backup_en = 1'b1;
        tick();
        backup_en = keep_en;
        for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
            tick();
            if (backup_ack) begin
                backup_ack = 1'b0;
                hold = 0;
            end
            if (backup_done) begin
                n_done++;
                fin = 1'b1;
                backup_en = 1'b0;
            end else if (backup_valid) begin
                if (hold == 1) begin
                    obs_q.push_back({backup_addr, backup_data});
                    backup_ack = 1'b1;
                end
                hold++;
            end
        end
        backup_en = 1'b0;
        check("sweep_done_pulse", n_done, 1);
        tick();
        check("sweep_done_one_cycle", backup_done, 1'b0);
        check("beat_count", obs_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            got = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
            check("beat", got, exp_q.pop_front());
        end
        obs_q.delete();
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        backup_en = 1'b0; backup_ack = 1'b0; restore_en = 1'b0;
        restore_addr = '0; restore_data = '0; rst_drtyctrl = 1'b0; pwr_off = 1'b0;
        tick(); tick();
        rst = 1'b0;

        check("rst_mask", dirty_mask, 8'h00);
        check("rst_valid", backup_valid, 1'b0);
        check("rst_busy", backup_busy, 1'b0);
        check("rst_done", backup_done, 1'b0);
        check("rst_addr", backup_addr, 3'd0);
        check("rst_data", backup_data, 32'h0);
        rd_check("rst_reg0", 3'd0, 32'h0);

        // Qualifying write, then equal-value rewrite
        wr(3'd3, 32'hA5);
        check("wr3_mask", dirty_mask, 8'h08);
        rd_check("wr3_data", 3'd3, 32'hA5);
        wr(3'd3, 32'hA5);
        check("rewrite3_mask", dirty_mask, 8'h08);

        rst_drtyctrl = 1'b1; tick(); rst_drtyctrl = 1'b0;
        check("drtyctrl_clear", dirty_mask, 8'h00);

        // Two-beat sweep over entries 1 and 5
        wr(3'd1, 32'h11);
        wr(3'd5, 32'h55);
        check("pre_sweep_mask", dirty_mask, 8'h22);
        exp_q.push_back({3'd1, 32'h11});
        exp_q.push_back({3'd5, 32'h55});
        run_sweep(1'b0);
        check("post_sweep_mask", dirty_mask, 8'h00);

        // Write to the in-flight entry keeps it dirty, beat carries old data
        wr(3'd5, 32'h5A);
        start_sweep();
        wait_valid(40);
        check("send5_addr", backup_addr, 3'd5);
        check("send5_data", backup_data, 32'h5A);
        wr(3'd5, 32'h1234);
        check("send5_hold_valid", backup_valid, 1'b1);
        check("send5_hold_data", backup_data, 32'h5A);
        backup_ack = 1'b1; tick(); backup_ack = 1'b0;
        wait_done(40);
        check("redirty5_mask", dirty_mask, 8'h20);
        rd_check("reg5_new", 3'd5, 32'h1234);

        // Restore aborts a sweep mid-SEND
        wr(3'd2, 32'h22);
        check("pre_abort_mask", dirty_mask, 8'h24);
        start_sweep();
        wait_valid(40);
        check("send2_addr", backup_addr, 3'd2);
        restore_en = 1'b1; restore_addr = 3'd2; restore_data = 32'h77;
        tick();
        restore_en = 1'b0;
        check("restore_abort_valid", backup_valid, 1'b0);
        check("restore_abort_busy", backup_busy, 1'b0);
        check("restore_abort_mask", dirty_mask, 8'h20);
        rd_check("restore_reg2", 3'd2, 32'h77);
        count_done("restore_abort_no_done", 4);

        // Restore wins over a same-cycle write
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'h99;
        restore_en = 1'b1; restore_addr = 3'd2; restore_data = 32'h66;
        tick();
        wr_en = 1'b0; restore_en = 1'b0;
        rd_check("prio_reg2", 3'd2, 32'h66);
        check("prio_mask", dirty_mask, 8'h20);

        // Dirty-control clear aborts a sweep
        wr(3'd3, 32'h3);
        start_sweep();
        wait_valid(40);
        check("send3_addr", backup_addr, 3'd3);
        rst_drtyctrl = 1'b1; tick(); rst_drtyctrl = 1'b0;
        check("drty_abort_valid", backup_valid, 1'b0);
        check("drty_abort_busy", backup_busy, 1'b0);
        check("drty_abort_mask", dirty_mask, 8'h00);
        count_done("drty_abort_no_done", 4);

        // First and last entry, with Backup_en held high throughout
        wr(3'd0, 32'h1);
        wr(3'd7, 32'h7);
        check("edge_mask", dirty_mask, 8'h81);
        exp_q.push_back({3'd0, 32'h1});
        exp_q.push_back({3'd7, 32'h7});
        run_sweep(1'b1);
        check("edge_post_mask", dirty_mask, 8'h00);
        check("edge_idle", backup_busy, 1'b0);

        // Power-off mid-sweep
        wr(3'd6, 32'h66);
        start_sweep();
        wait_valid(40);
        check("send6_addr", backup_addr, 3'd6);
        pwr_off = 1'b1; tick(); pwr_off = 1'b0;
`ifdef REGBANK_IC_PWR_SIM_EN
        check("pwr_valid", backup_valid, 1'b0);
        check("pwr_busy", backup_busy, 1'b0);
        check("pwr_addr", backup_addr, 3'd0);
        check("pwr_data", backup_data, 32'h0);
        check("pwr_mask", dirty_mask, 8'h00);
        rd_check("pwr_reg6", 3'd6, 32'h0);
`else
        check("pwr_ign_valid", backup_valid, 1'b1);
        check("pwr_ign_addr", backup_addr, 3'd6);
        check("pwr_ign_mask", dirty_mask, 8'h40);
        rd_check("pwr_ign_reg6", 3'd6, 32'h66);
        backup_ack = 1'b1; tick(); backup_ack = 1'b0;
        wait_done(40);
        check("pwr_ign_post_mask", dirty_mask, 8'h00);
`endif

        // Reset mid-sweep beats a simultaneous ack and write
        wr(3'd4, 32'h44);
        start_sweep();
        wait_valid(40);
        check("send4_addr", backup_addr, 3'd4);
        rst = 1'b1; backup_ack = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'hBEEF;
        tick();
        rst = 1'b0; backup_ack = 1'b0; wr_en = 1'b0;
        check("midrst_valid", backup_valid, 1'b0);
        check("midrst_busy", backup_busy, 1'b0);
        check("midrst_done", backup_done, 1'b0);
        check("midrst_addr", backup_addr, 3'd0);
        check("midrst_data", backup_data, 32'h0);
        check("midrst_mask", dirty_mask, 8'h00);
        rd_check("midrst_reg4", 3'd4, 32'h0);
        rd_check("midrst_reg1", 3'd1, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
